imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts a 32-bit instruction, a one-hot format select and a tag over a valid/ready handshake. It emits the XLEN-wide sign- or zero-extended immediate one cycle later through a 2-entry skid buffer. It adds XLEN=64 support, the CSR Z-type immediate, select-error detection and full backpressure, none of which the current combinational extractor has.

## Interface
- XLEN, 32, immediate width; legal values are 32 and 64.
- TAG_W, 5, width of the sideband tag carried alongside each instruction (e.g. rd index or ROB id).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_instr  in  32  raw instruction word.
- in_sel  in  6  one-hot format select: bit0 I, bit1 U, bit2 S, bit3 B, bit4 J, bit5 Z.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the current output beat.
- out_err  out  1  the beat's in_sel was illegal (see Configuration).
- err_cnt  out  8  saturating count of accepted illegal beats.

## Operation
- Immediate formats (sign = instr[31], sign-extended to XLEN):
  - I: instr[31:20].
  - U: {instr[31:12], 12'b0}; sign-extended above bit 31 when XLEN=64.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Z: zero-extended instr[19:15].
- Extraction is combinational on the input beat. The result is stored together with tag and err.
- Storage: output register (OUT) plus skid register (SKID). Each holds {valid, imm, tag, err}.
- States:
  - EMPTY: OUT and SKID invalid.
  - ONE: OUT valid.
  - FULL: OUT and SKID valid.
- in_ready = !SKID.valid && !rst. It is a registered-state function only; there is no combinational path from out_ready.
- Accept while OUT is empty, or OUT is draining this cycle: the beat loads OUT.
- Accept while OUT is held (out_valid && !out_ready): the beat loads SKID; the state goes to FULL.
- FULL with out_ready high: SKID moves to OUT and SKID is cleared. No accept is possible this cycle.
- Simultaneous accept and drain in ONE: OUT takes the new beat; the state stays ONE.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- out_imm, out_tag and out_err hold stable while out_valid && !out_ready.
- err_cnt increments on each accepted beat whose err=1. It saturates at 255 with no wrap.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat/cycle while out_ready stays high.
- Reset values:
  - out_valid=0, out_imm=0, out_tag=0, out_err=0, err_cnt=0.
  - SKID invalid; in_ready=0 while rst is high, 1 in the first cycle after.
- Reset mid-operation: all buffered beats are discarded in the reset cycle, and no output is presented the next cycle. Handshakes presented during reset are ignored.

## Configuration
- IMM_SELCHK_EN defined:
  - in_sel must be exactly one-hot. Zero-hot or multi-hot gives out_imm=0 and out_err=1.
  - err_cnt is live.
- IMM_SELCHK_EN undefined:
  - Priority decode I > U > S > B > J > Z; in_sel=0 falls back to J.
  - out_err is tied 0 and err_cnt is tied 0; the checker logic is not synthesised.

## Test plan
- XLEN=32, continuous flow, out_ready=1:
  - 0xFFF00093 sel I → 0xFFFFFFFF.
  - 0xFE000EE3 sel B → 0xFFFFFFFC.
  - 0x0080006F sel J → 0x00000008.
  - 0x123450B7 sel U → 0x12345000.
  - Each output appears the cycle after accept, back-to-back.
- XLEN=64:
  - 0x800000B7 sel U → 0xFFFFFFFF80000000.
  - Instruction with instr[19:15]=5'b11111, sel Z → 0x000000000000001F.
- Backpressure:
  - Hold out_ready=0 and offer 3 beats with tags 1, 2, 3 → tags 1 and 2 are accepted, then in_ready=0.
  - Release out_ready → outputs in order 1, 2, then 3 after it is accepted; out_imm is stable while stalled.
- IMM_SELCHK_EN defined:
  - sel 6'b000011 → out_imm=0, out_err=1, err_cnt=1.
  - 300 illegal beats → err_cnt=255.
- IMM_SELCHK_EN undefined:
  - sel 6'b000011 → I-type result, out_err=0.
  - sel 0 → J-type result.
- Reset mid-operation:
  - In FULL, assert rst for one cycle → out_valid=0, err_cnt=0, in_ready=0 during reset.
  - in_ready=1 the cycle after; no stale beat is emitted.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator for the decode stage.
// Extracts the I/U/S/B/J/Z immediate from a 32-bit instruction, extends it to
// XLEN bits and presents it one cycle later through a 2-entry skid buffer.
// Optional select checker: define IMM_SELCHK_EN to require a strictly one-hot
// in_sel and to enable out_err / err_cnt; otherwise a priority decode is used.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [5:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t           state;

    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  imm_u;
    logic [XLEN-1:0]  imm_s;
    logic [XLEN-1:0]  imm_b;
    logic [XLEN-1:0]  imm_j;
    logic [XLEN-1:0]  imm_z;

    logic [XLEN-1:0]  beat_imm;
    logic             beat_err;

    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_err;

    logic             accept;
    logic             unused_opcode;

    // The opcode field plays no part in immediate extraction.
    assign unused_opcode = ^in_instr[6:0];

    // Per-format immediates, all sign-extended from instr[31] except Z.
    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
    assign imm_z = {{(XLEN-5){1'b0}}, in_instr[19:15]};

    // U already fills 32 bits, so it only needs extension on wide datapaths.
    if (XLEN > 32) begin : g_u_wide
        assign imm_u = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
    end else begin : g_u_narrow
        assign imm_u = {in_instr[31:12], 12'b0};
    end

    // Select the immediate for the incoming beat and flag an illegal select.
    always_comb begin
        beat_imm = '0;
        beat_err = 1'b0;
`ifdef IMM_SELCHK_EN
        case (in_sel)
            6'b000001: beat_imm = imm_i;
            6'b000010: beat_imm = imm_u;
            6'b000100: beat_imm = imm_s;
            6'b001000: beat_imm = imm_b;
            6'b010000: beat_imm = imm_j;
            6'b100000: beat_imm = imm_z;
            default:   beat_err = 1'b1;
        endcase
`else
        if (in_sel[0]) begin
            beat_imm = imm_i;
        end else if (in_sel[1]) begin
            beat_imm = imm_u;
        end else if (in_sel[2]) begin
            beat_imm = imm_s;
        end else if (in_sel[3]) begin
            beat_imm = imm_b;
        end else if (in_sel[4]) begin
            beat_imm = imm_j;
        end else if (in_sel[5]) begin
            beat_imm = imm_z;
        end else begin
            beat_imm = imm_j;
        end
`endif
    end

    // Readiness depends only on registered state so out_ready never reaches in_ready.
    assign in_ready  = (state != FULL) && !rst;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;

    // Skid-buffer controller: OUT is the presented beat, SKID catches one beat under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_imm  <= '0;
            out_tag  <= '0;
            out_err  <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_err <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_imm <= beat_imm;
                        out_tag <= in_tag;
                        out_err <= beat_err;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        out_imm <= beat_imm;
                        out_tag <= in_tag;
                        out_err <= beat_err;
                    end else if (accept) begin
                        skid_imm <= beat_imm;
                        skid_tag <= in_tag;
                        skid_err <= beat_err;
                        state    <= FULL;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        out_imm <= skid_imm;
                        out_tag <= skid_tag;
                        out_err <= skid_err;
                        state   <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

`ifdef IMM_SELCHK_EN
    logic [7:0] err_cnt_q;

    // Saturating count of accepted beats whose select was illegal.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (accept && beat_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: checks imm_gen_pipe at XLEN=32 and XLEN=64 side by side.
// Both instances share inputs; a queue-based FIFO model with an arithmetic
// immediate reference predicts readiness, ordering and every output beat.
`timescale 1ns/1ps
module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [31:0]      in_instr;
    logic [5:0]       in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             in_ready32;
    logic             out_valid32;
    logic [31:0]      out_imm32;
    logic [TAG_W-1:0] out_tag32;
    logic             out_err32;
    logic [7:0]       err_cnt32;

    logic             in_ready64;
    logic             out_valid64;
    logic [63:0]      out_imm64;
    logic [TAG_W-1:0] out_tag64;
    logic             out_err64;
    logic [7:0]       err_cnt64;

    typedef struct {
        logic [63:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } beat_t;

    beat_t sb[$];
    beat_t new_beat;
    int    depth;
    int    model_errs = 0;
    int    test_count = 0;
    int    fail_count = 0;

    logic [31:0] instr_v [6];
    logic [5:0]  sel_v   [6];
    logic [31:0] exp32_v [6];
    logic [63:0] exp64_v [6];

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32),
        .out_err(out_err32), .err_cnt(err_cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64),
        .out_err(out_err64), .err_cnt(err_cnt64)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Interpret the low 'bits' bits of value as a two's-complement number.
    function automatic longint sext(input longint value, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        if (value >= half) return value - (half * 2);
        return value;
    endfunction

    // Reference immediate built from field arithmetic on the instruction value.
    function automatic beat_t refBeat(input logic [31:0] instr, input logic [5:0] sel,
                                      input logic [TAG_W-1:0] tag);
        beat_t  b;
        longint u;
        int     fmt;
        u     = longint'({32'b0, instr});
        b.tag = tag;
        b.err = 1'b0;
        b.imm = '0;
        fmt   = -1;
`ifdef IMM_SELCHK_EN
        if ($countones(sel) == 1) begin
            for (int i = 0; i < 6; i++)
                if (sel[i]) fmt = i;
        end else begin
            b.err = 1'b1;
        end
`else
        fmt = 4;
        for (int i = 5; i >= 0; i--)
            if (sel[i]) fmt = i;
`endif
        case (fmt)
            0: b.imm = sext(u >> 20, 12);
            1: b.imm = sext((u >> 12) * 4096, 32);
            2: b.imm = sext((u >> 25) * 32 + ((u >> 7) % 32), 12);
            3: b.imm = sext((u >> 31) * 4096 + ((u >> 7) % 2) * 2048
                            + ((u >> 25) % 64) * 32 + ((u >> 8) % 16) * 2, 13);
            4: b.imm = sext((u >> 31) * 1048576 + ((u >> 12) % 256) * 4096
                            + ((u >> 20) % 2) * 2048 + ((u >> 21) % 1024) * 2, 21);
            5: b.imm = (u >> 15) % 32;
            default: b.imm = '0;
        endcase
        return b;
    endfunction

    // Scoreboard on every falling edge: compare both DUTs with the FIFO model, then advance it.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_ready32", 64'(in_ready32), 64'd0);
            checkOutput("rst_ready64", 64'(in_ready64), 64'd0);
            sb.delete();
            model_errs = 0;
        end else begin
            depth = sb.size();
            checkOutput("ready32", 64'(in_ready32), 64'(depth < 2));
            checkOutput("ready64", 64'(in_ready64), 64'(depth < 2));
            checkOutput("valid32", 64'(out_valid32), 64'(depth > 0));
            checkOutput("valid64", 64'(out_valid64), 64'(depth > 0));
            checkOutput("errcnt32", 64'(err_cnt32), 64'(model_errs));
            checkOutput("errcnt64", 64'(err_cnt64), 64'(model_errs));
            if (depth > 0) begin
                checkOutput("imm32", 64'(out_imm32), 64'(sb[0].imm[31:0]));
                checkOutput("imm64", out_imm64, sb[0].imm);
                checkOutput("tag32", 64'(out_tag32), 64'(sb[0].tag));
                checkOutput("tag64", 64'(out_tag64), 64'(sb[0].tag));
                checkOutput("err32", 64'(out_err32), 64'(sb[0].err));
                checkOutput("err64", 64'(out_err64), 64'(sb[0].err));
                if (out_ready) void'(sb.pop_front());
            end
            if (in_valid && (depth < 2)) begin
                new_beat = refBeat(in_instr, in_sel, in_tag);
                sb.push_back(new_beat);
                if (new_beat.err && (model_errs < 255)) model_errs++;
            end
        end
    end

    // Present one beat just after a rising edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic [5:0] sel,
                                 input logic [TAG_W-1:0] tag);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_instr = instr;
        in_sel   = sel;
        in_tag   = tag;
    endtask

    // Drop in_valid after the next edge and wait for the following falling edge.
    task automatic idleToNegedge();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Directed scenarios followed by a randomized run.
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_sel    = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        instr_v = '{32'hFFF00093, 32'hFE000EE3, 32'h0080006F,
                    32'h123450B7, 32'h800000B7, 32'h000F8073};
        sel_v   = '{6'b000001, 6'b001000, 6'b010000,
                    6'b000010, 6'b000010, 6'b100000};
        exp32_v = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008,
                    32'h12345000, 32'h80000000, 32'h0000001F};
        exp64_v = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0000000000000008,
                    64'h0000000012345000, 64'hFFFFFFFF80000000, 64'h000000000000001F};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_valid", 64'(out_valid32), 64'd0);
        checkOutput("reset_imm32", 64'(out_imm32), 64'd0);
        checkOutput("reset_imm64", out_imm64, 64'd0);
        checkOutput("reset_tag", 64'(out_tag32), 64'd0);
        checkOutput("reset_err", 64'(out_err32), 64'd0);
        checkOutput("reset_errcnt", 64'(err_cnt32), 64'd0);
        checkOutput("reset_ready", 64'(in_ready32), 64'd1);

        // Continuous flow: each result is visible the cycle after its accept.
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(instr_v[k], sel_v[k], TAG_W'(k));
            @(negedge clk);
            if (k > 0) begin
                checkOutput($sformatf("flow%0d_valid", k - 1), 64'(out_valid32), 64'd1);
                checkOutput($sformatf("flow%0d_imm32", k - 1), 64'(out_imm32), 64'(exp32_v[k - 1]));
                checkOutput($sformatf("flow%0d_imm64", k - 1), out_imm64, exp64_v[k - 1]);
                checkOutput($sformatf("flow%0d_tag", k - 1), 64'(out_tag32), 64'(k - 1));
            end
        end
        idleToNegedge();
        checkOutput("flow5_imm32", 64'(out_imm32), 64'(exp32_v[5]));
        checkOutput("flow5_imm64", out_imm64, exp64_v[5]);

        // Select handling for illegal / non-one-hot selects.
`ifdef IMM_SELCHK_EN
        applyStimulus(32'hFFF00093, 6'b000011, 5'd7);
        idleToNegedge();
        checkOutput("selchk_imm", 64'(out_imm32), 64'd0);
        checkOutput("selchk_err", 64'(out_err32), 64'd1);
        checkOutput("selchk_cnt", 64'(err_cnt32), 64'd1);
        for (int n = 0; n < 300; n++) begin
            applyStimulus($urandom(), 6'b000011, TAG_W'(n));
        end
        idleToNegedge();
        checkOutput("selchk_sat32", 64'(err_cnt32), 64'd255);
        checkOutput("selchk_sat64", 64'(err_cnt64), 64'd255);
`else
        applyStimulus(32'hFFF00093, 6'b000011, 5'd7);
        idleToNegedge();
        checkOutput("prio_imm", 64'(out_imm32), 64'hFFFFFFFF);
        checkOutput("prio_err", 64'(out_err32), 64'd0);
        applyStimulus(32'h0080006F, 6'b000000, 5'd8);
        idleToNegedge();
        checkOutput("zero_sel_imm", 64'(out_imm32), 64'd8);
        checkOutput("zero_sel_cnt", 64'(err_cnt32), 64'd0);
`endif

        // Backpressure: two beats buffered, third held off until space frees.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h123450B7;
        in_sel    = 6'b000010;
        in_tag    = 5'd1;
        @(negedge clk);
        checkOutput("bp_ready_t1", 64'(in_ready32), 64'd1);
        @(posedge clk);
        #1;
        in_instr = 32'hFFF00093;
        in_sel   = 6'b000001;
        in_tag   = 5'd2;
        @(negedge clk);
        checkOutput("bp_ready_t2", 64'(in_ready32), 64'd1);
        @(posedge clk);
        #1;
        in_instr = 32'h0080006F;
        in_sel   = 6'b010000;
        in_tag   = 5'd3;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            checkOutput("bp_full_ready", 64'(in_ready32), 64'd0);
            checkOutput("bp_hold_tag", 64'(out_tag32), 64'd1);
            checkOutput("bp_hold_imm", 64'(out_imm32), 64'h12345000);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_rel_tag1", 64'(out_tag32), 64'd1);
        checkOutput("bp_rel_ready", 64'(in_ready32), 64'd0);
        @(negedge clk);
        checkOutput("bp_rel_tag2", 64'(out_tag32), 64'd2);
        checkOutput("bp_rel_imm2", 64'(out_imm32), 64'hFFFFFFFF);
        checkOutput("bp_rel_ready2", 64'(in_ready32), 64'd1);
        idleToNegedge();
        checkOutput("bp_rel_tag3", 64'(out_tag32), 64'd3);
        checkOutput("bp_rel_imm3", 64'(out_imm32), 64'd8);

        // Reset while FULL discards both buffered beats.
        applyStimulus(32'hFFF00093, 6'b000011, 5'd4);
        out_ready = 1'b0;
        applyStimulus(32'h123450B7, 6'b000010, 5'd5);
        idleToNegedge();
        checkOutput("mid_full_ready", 64'(in_ready32), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_ready", 64'(in_ready32), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid_after_valid", 64'(out_valid32), 64'd0);
        checkOutput("mid_after_cnt", 64'(err_cnt32), 64'd0);
        checkOutput("mid_after_ready", 64'(in_ready32), 64'd1);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checkOutput("mid_no_stale", 64'(out_valid64), 64'd0);
        end

        // Randomized traffic with random stalls, selects and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst      = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = $urandom();
            case ($urandom_range(0, 7))
                0:       in_sel = 6'($urandom());
                1:       in_sel = 6'b000000;
                default: in_sel = 6'b000001 << $urandom_range(0, 5);
            endcase
            in_tag    = TAG_W'($urandom());
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
